// File: rtl/slave_rd_sched_if.sv
// Signal bundle between host-side readers, the read scheduler and the slave_device read port.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface slave_rd_sched_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] addr_i;
  logic [NREQ*8-1:0]  len_i;
  logic [NREQ-1:0]    gnt;
  logic               ram_rd_rq;
  logic [15:0]        rd_addr;
  logic [7:0]         data_i;
  logic [7:0]         rdata;
  logic               rvalid;
  logic [IDW-1:0]     rid;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport slave (
    input  req, addr_i, len_i, data_i,
    output gnt, ram_rd_rq, rd_addr, rdata, rvalid, rid, done, busy
  );

  modport master (
    output req, addr_i, len_i, data_i,
    input  gnt, ram_rd_rq, rd_addr, rdata, rvalid, rid, done, busy
  );
endinterface

// File: rtl/slave_rd_sched.sv
// Round-robin burst read scheduler sharing the slave_device RAM read port between NREQ
// requesters; returns every byte tagged with its owner id.
module slave_rd_sched #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned IDW    = 2
) (
  input  logic         clk,
  input  logic         rst_l,
  slave_rd_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  start_q;
  logic [15:0]     addr_q;
  logic [7:0]      cnt_q;
  logic            rq_q;
  logic            busy_q;
  logic            rvalid_q;
  logic [7:0]      rdata_q;
  logic [IDW-1:0]  rid_q;
  logic [2:0]      pend_q;

  logic            beat_ret;
  logic [2:0]      pend_nxt;
  logic [IDW-1:0]  pick;
  logic            found;
  logic [IDW-1:0]  nxt_start;
  logic            fin;

  // beat_ret marks the cycle in which data_i carries a byte for an earlier strobe
  if (RD_LAT == 0) begin : g_lat0
    assign beat_ret = rq_q;
  end else begin : g_latn
    logic [RD_LAT-1:0] pipe_q;
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= RD_LAT'({pipe_q, rq_q});
      end
    end
    assign beat_ret = pipe_q[RD_LAT-1];
  end

  // Beats strobed but not yet captured into rdata
  assign pend_nxt = pend_q + {2'b00, rq_q} - {2'b00, beat_ret};

  always_comb begin
    pick  = start_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req[(32'(start_q) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IDW'((32'(start_q) + i) % NREQ);
      end
    end
  end

  assign nxt_start = (32'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;

  // With zero latency the last beat is captured on the same edge that ends ISSUE
  assign fin = ((state_q == StIssue) && (cnt_q == 8'd1) && (pend_nxt == 3'd0)) ||
               ((state_q == StDrain) && (pend_nxt == 3'd0));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      id_q     <= '0;
      start_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rq_q     <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      pend_q   <= '0;
    end else begin
      done_q   <= '0;
      rvalid_q <= beat_ret;
      pend_q   <= pend_nxt;
      if (beat_ret) begin
        rdata_q <= bus.data_i;
        rid_q   <= id_q;
      end
      if (fin) begin
        rq_q    <= 1'b0;
        done_q  <= gnt_q;
        gnt_q   <= '0;
        busy_q  <= 1'b0;
        start_q <= nxt_start;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (found) begin
              id_q    <= pick;
              gnt_q   <= NREQ'(1) << pick;
              busy_q  <= 1'b1;
              addr_q  <= bus.addr_i[16*pick +: 16];
              cnt_q   <= bus.len_i[8*pick +: 8];
              rq_q    <= (bus.len_i[8*pick +: 8] != 8'd0);
              state_q <= StIssue;
            end
          end
          StIssue: begin
            if (cnt_q <= 8'd1) begin
              rq_q    <= 1'b0;
              state_q <= StDrain;
            end else begin
              cnt_q  <= cnt_q - 8'd1;
              addr_q <= addr_q + 16'd1;
            end
          end
          StDrain: begin
            state_q <= StDrain;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.ram_rd_rq = rq_q;
  assign bus.rd_addr   = addr_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rid       = rid_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_l) $onehot0(gnt_q));
  a_rq_in_issue: assert property (@(posedge clk) disable iff (!rst_l)
                                  rq_q |-> (state_q == StIssue));

endmodule

// File: tb/tb_slave_rd_sched.sv
// Randomized scoreboard bench for slave_rd_sched: a cycle-level burst model predicts strobes,
// returned bytes, done pulses and grant windows; a negedge monitor compares DUT outputs.
module tb_slave_rd_sched;
  localparam int unsigned NREQ = 3;
  localparam int unsigned LAT  = 2;
  localparam int unsigned IDW  = 2;
  localparam int          HI   = (LAT == 0) ? 0 : LAT - 1;

  typedef struct {
    int cyc;
    int id;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  slave_rd_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  slave_rd_sched #(.NREQ(NREQ), .RD_LAT(LAT), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp_v);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // slave_device stand-in: fixed RAM contents, read latency LAT, header counter on address 0
  logic [7:0]  ram  [0:65535];
  logic [15:0] hist [0:3];
  int          hdr_seen = 0;

  always @(posedge clk) begin
    if (bus.ram_rd_rq && bus.rd_addr == 16'h0000) hdr_seen++;
    hist[0] <= bus.rd_addr;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
    hist[3] <= hist[2];
  end

  always_comb begin
    if (LAT == 0) bus.data_i = ram[bus.rd_addr];
    else          bus.data_i = ram[hist[HI]];
  end

  // Reference model: one burst at a time, RR search from last+1, arithmetic event timeline
  ev_t q_strb[$];
  ev_t q_beat[$];
  ev_t q_done[$];
  int  cyc = 0;
  int  next_ok = 0;
  int  last = NREQ - 1;
  int  g_id = 0, g_start = 0, g_end = 0;
  int  exp_hdr = 0;

  always @(posedge clk) begin
    int w, len, a, d, ad;
    cyc++;
    if (!rst_l) begin
      foreach (q_strb[i]) if (q_strb[i].val == 0) exp_hdr--;
      q_strb.delete();
      q_beat.delete();
      q_done.delete();
      last    = NREQ - 1;
      next_ok = 0;
      g_start = 0;
      g_end   = 0;
    end else if (cyc >= next_ok && bus.req != '0) begin
      w = -1;
      for (int i = 1; i <= NREQ; i++) begin
        if (w < 0 && bus.req[(last + i) % NREQ]) w = (last + i) % NREQ;
      end
      len = int'(bus.len_i[8*w +: 8]);
      a   = int'(bus.addr_i[16*w +: 16]);
      for (int i = 0; i < len; i++) begin
        ad = (a + i) % 65536;
        q_strb.push_back('{cyc + i, w, ad});
        q_beat.push_back('{cyc + i + LAT + 1, w, int'(ram[ad])});
        if (ad == 0) exp_hdr++;
      end
      d = (len == 0) ? cyc + 2 : cyc + len + LAT;
      q_done.push_back('{d, w, 0});
      g_id    = w;
      g_start = cyc;
      g_end   = d;
      next_ok = d + 1;
      last    = w;
    end
  end

  // Monitor: sample at negedge, pop expected events as the DUT presents them
  always @(negedge clk) begin
    ev_t e;
    int  eg;
    if (rst_l) begin
      while (q_strb.size() > 0 && q_strb[0].cyc < cyc) begin
        e = q_strb.pop_front();
        chk(1'b0, "strobe_missing", cyc, e.cyc);
      end
      while (q_beat.size() > 0 && q_beat[0].cyc < cyc) begin
        e = q_beat.pop_front();
        chk(1'b0, "rvalid_missing", cyc, e.cyc);
      end
      while (q_done.size() > 0 && q_done[0].cyc < cyc) begin
        e = q_done.pop_front();
        chk(1'b0, "done_missing", cyc, e.cyc);
      end
      if (bus.ram_rd_rq) begin
        if (q_strb.size() == 0) begin
          chk(1'b0, "strobe_unexpected", int'(bus.rd_addr), -1);
        end else begin
          e = q_strb.pop_front();
          chk(e.cyc == cyc, "strobe_cycle", cyc, e.cyc);
          chk(int'(bus.rd_addr) == e.val, "rd_addr", int'(bus.rd_addr), e.val);
        end
      end
      if (bus.rvalid) begin
        if (q_beat.size() == 0) begin
          chk(1'b0, "rvalid_unexpected", int'(bus.rdata), -1);
        end else begin
          e = q_beat.pop_front();
          chk(e.cyc == cyc, "rvalid_cycle", cyc, e.cyc);
          chk(int'(bus.rid) == e.id, "rid", int'(bus.rid), e.id);
          chk(int'(bus.rdata) == e.val, "rdata", int'(bus.rdata), e.val);
        end
      end
      if (bus.done != '0) begin
        if (q_done.size() == 0) begin
          chk(1'b0, "done_unexpected", int'(bus.done), 0);
        end else begin
          e = q_done.pop_front();
          chk(e.cyc == cyc, "done_cycle", cyc, e.cyc);
          chk(int'(bus.done) == (1 << e.id), "done_bits", int'(bus.done), 1 << e.id);
        end
      end
      eg = (cyc >= g_start && cyc < g_end) ? (1 << g_id) : 0;
      chk(int'(bus.gnt) == eg, "gnt", int'(bus.gnt), eg);
      chk(bus.busy == (eg != 0), "busy", int'(bus.busy), int'(eg != 0));
    end
  end

  // Stimulus: one process owns every bench-driven input
  logic [NREQ-1:0] active = '0;

  task automatic raise(input int k, input logic [15:0] a, input logic [7:0] l);
    bus.addr_i[16*k +: 16] = a;
    bus.len_i[8*k +: 8]    = l;
    bus.req[k]             = 1'b1;
    active[k]              = 1'b1;
  endtask

  task automatic tick(input bit rnd);
    logic [15:0] a;
    logic [7:0]  l;
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      if (bus.done[k]) begin
        bus.req[k] = 1'b0;
        active[k]  = 1'b0;
      end
    end
    if (rnd) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!active[k]) begin
          if ($urandom_range(5, 0) == 0) begin
            case ($urandom_range(3, 0))
              0:       a = 16'hFFF8 + 16'($urandom_range(7, 0));
              1:       a = 16'($urandom_range(3, 0));
              default: a = 16'($urandom);
            endcase
            if ($urandom_range(9, 0) == 0)       l = 8'd0;
            else if ($urandom_range(29, 0) == 0) l = 8'($urandom_range(255, 200));
            else                                 l = 8'($urandom_range(12, 1));
            raise(k, a, l);
          end
        end else if (bus.gnt[k] && $urandom_range(7, 0) == 0) begin
          // Owner lets go and scribbles its inputs; the burst must be unaffected
          bus.req[k]             = 1'b0;
          bus.addr_i[16*k +: 16] = 16'($urandom);
          bus.len_i[8*k +: 8]    = 8'($urandom);
        end
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick(1'b0);
      if (active == '0 && !bus.busy) return;
    end
    chk(1'b0, "idle_timeout", int'(active), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(bus.gnt == '0, {tag, "_gnt"}, int'(bus.gnt), 0);
    chk(bus.done == '0, {tag, "_done"}, int'(bus.done), 0);
    chk(!bus.busy, {tag, "_busy"}, int'(bus.busy), 0);
    chk(!bus.ram_rd_rq, {tag, "_rd_rq"}, int'(bus.ram_rd_rq), 0);
    chk(bus.rd_addr == 16'h0, {tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk(!bus.rvalid, {tag, "_rvalid"}, int'(bus.rvalid), 0);
    chk(bus.rdata == 8'h0, {tag, "_rdata"}, int'(bus.rdata), 0);
    chk(bus.rid == '0, {tag, "_rid"}, int'(bus.rid), 0);
  endtask

  initial begin
    int h0, ns, waited;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    bus.req    = '0;
    bus.addr_i = '0;
    bus.len_i  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_l = 1'b1;

    // Single burst, then two requesters contending twice
    tick(1'b0);
    raise(0, 16'h0010, 8'd4);
    wait_idle(100);
    for (int r = 0; r < 2; r++) begin
      raise(0, 16'h2000 + 16'(r * 16), 8'd3);
      raise(1, 16'h3000 + 16'(r * 16), 8'd3);
      wait_idle(100);
    end

    // Zero-length burst
    raise(1, 16'h5555, 8'd0);
    wait_idle(100);

    // Address wrap through 0
    h0 = hdr_seen;
    raise(2, 16'hFFFE, 8'd4);
    wait_idle(100);
    chk(hdr_seen - h0 == 1, "hdr_wrap", hdr_seen - h0, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) tick(1'b1);
    wait_idle(3000);

    // Reset on the 3rd beat of a length-8 burst
    raise(0, 16'h4000, 8'd8);
    ns = 0;
    for (int i = 0; i < 40 && ns < 3; i++) begin
      tick(1'b0);
      if (bus.ram_rd_rq) ns++;
    end
    chk(ns == 3, "abort_beats_seen", ns, 3);
    rst_l = 1'b0;
    #1;
    chk_zero("abort");
    for (int k = 0; k < NREQ; k++) raise(k, 16'h6000 + 16'(k * 256), 8'd2);
    tick(1'b0);
    tick(1'b0);
    rst_l = 1'b1;
    waited = 0;
    while (bus.gnt == '0 && waited < 10) begin
      tick(1'b0);
      waited++;
    end
    chk(bus.gnt == NREQ'(1), "post_reset_gnt", int'(bus.gnt), 1);
    wait_idle(200);

    repeat (LAT + 4) tick(1'b0);
    chk(q_strb.size() == 0, "strb_q_empty", q_strb.size(), 0);
    chk(q_beat.size() == 0, "beat_q_empty", q_beat.size(), 0);
    chk(q_done.size() == 0, "done_q_empty", q_done.size(), 0);
    chk(hdr_seen == exp_hdr, "hdr_count", hdr_seen, exp_hdr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
